memory_arbiter: RTL

Two-port arbiter and sequencer for the single-cycle processor's 50×8 data memory. It accepts read/write requests from two requesters, for example the processor datapath (port 0) and a debug/loader port (port 1), using valid/ready handshakes. It grants them round-robin, drives the memory's write/read strobes, address and write data for exactly one cycle, and returns the 1-cycle-late read data (or a write acknowledge) to the winning requester. Out-of-range addresses are rejected without touching the memory.

---
 rtl/memory_arbiter_pkg.sv | 8 +
 rtl/memory_arbiter_if.sv | 30 +++
 rtl/memory_arbiter_rr.sv | 27 ++
 rtl/memory_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared constants and FSM state encoding for the two-port data-memory arbiter.
package memory_arbiter_pkg;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 50;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// Requester handshake plus data-memory strobe bundle for memory_arbiter.
interface memory_arbiter_if #(
   parameter int ADDR_W = memory_arbiter_pkg::ADDR_W,
   parameter int DATA_W = memory_arbiter_pkg::DATA_W
);
   logic [1:0]          req_valid;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          req_ready;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;
   logic                mem_write;
   logic                mem_read;
   logic [ADDR_W-1:0]   mem_endereco;
   logic [DATA_W-1:0]   mem_valor_escrita;
   logic [DATA_W-1:0]   mem_valor_saida;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_valor_saida,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_write, mem_read, mem_endereco, mem_valor_escrita
   );
   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_valor_saida,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_write, mem_read, mem_endereco, mem_valor_escrita
   );
endinterface

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin grant with the last_grant register; on conflict the
// port that did not win last time is chosen.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);
   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Resets to port 1 so port 0 takes the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_grant <= 1'b1;
      else if (update) last_grant <= gnt[1];
   end
endmodule

// File: rtl/memory_arbiter.sv
// Accept -> issue one memory strobe -> respond; one transaction per 3 cycles.
import memory_arbiter_pkg::*;

module memory_arbiter #(
   parameter int ADDR_W = memory_arbiter_pkg::ADDR_W,
   parameter int DATA_W = memory_arbiter_pkg::DATA_W,
   parameter int DEPTH  = memory_arbiter_pkg::DEPTH
) (
   input logic              clk,
   input logic              rst_n,
   memory_arbiter_if.slave  bus
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [1:0]        gnt;
   logic              accept, sel, sel_we, sel_err;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              lat_port, lat_we, lat_err;

   rr_arbiter_2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.req_valid),
      .update (accept),
      .gnt    (gnt)
   );

   assign accept    = (state == IDLE) && (|gnt);
   assign sel       = gnt[1];
   assign sel_we    = sel ? bus.req_we[1] : bus.req_we[0];
   assign sel_addr  = sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
   assign sel_wdata = sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
   assign sel_err   = {1'b0, sel_addr} >= LIMIT;

   // Ready is combinational but held low while reset is asserted.
   assign bus.req_ready = (accept && rst_n) ? gnt : 2'b00;
   assign bus.rsp_rdata = (state == RESP && !lat_we && !lat_err) ? bus.mem_valor_saida : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         lat_port              <= 1'b0;
         lat_we                <= 1'b0;
         lat_err               <= 1'b0;
         bus.mem_write         <= 1'b0;
         bus.mem_read          <= 1'b0;
         bus.mem_endereco      <= '0;
         bus.mem_valor_escrita <= '0;
         bus.rsp_valid         <= 2'b00;
         bus.rsp_err           <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state                 <= ISSUE;
               lat_port              <= sel;
               lat_we                <= sel_we;
               lat_err               <= sel_err;
               bus.mem_write         <= sel_we & ~sel_err;
               bus.mem_read          <= ~sel_we & ~sel_err;
               bus.mem_endereco      <= sel_addr;
               bus.mem_valor_escrita <= sel_wdata;
            end
            ISSUE: begin
               state                 <= RESP;
               bus.mem_write         <= 1'b0;
               bus.mem_read          <= 1'b0;
               bus.mem_endereco      <= '0;
               bus.mem_valor_escrita <= '0;
               bus.rsp_valid         <= lat_port ? 2'b10 : 2'b01;
               bus.rsp_err           <= lat_err;
            end
            RESP: begin
               state         <= IDLE;
               bus.rsp_valid <= 2'b00;
               bus.rsp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
